lsu_cdb_unit: RTL and testbench

- Load/store functional unit: accepts issued memory ops from the LSU reservation-station path, accesses a private word-addressed data memory, and broadcasts results on the common data bus (CDB) slot 1.
- Transmitter end of the CDB consumed by the ROB and the reservation stations.
- Backpressure to the instruction buffer via lsu_full.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/lsu_req_fifo.sv | 53 +++++
 rtl/lsu_cdb_unit.sv | 133 +++++++++++++
 tb/tb_lsu_cdb_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the load/store unit and its request queue.
package cpu_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int DATA_W    = 16;
    localparam int OPC_W     = 4;

    localparam logic [OPC_W-1:0]  OP_LD         = 4'hA;
    localparam logic [OPC_W-1:0]  OP_ST         = 4'hB;
    localparam logic [DATA_W-1:0] BAD_ADDR_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_BCAST
    } lsu_state_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [OPC_W-1:0]     opcode;
        logic [DATA_W-1:0]    a_value;
        logic [DATA_W-1:0]    b_value;
    } lsu_req_t;

endpackage

// File: rtl/lsu_req_fifo.sv
// Two-entry request queue in front of the LSU; slot0 is always the head.
module lsu_req_fifo
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  lsu_req_t   push_data,
    input  logic       pop,
    output lsu_req_t   head,
    output logic [1:0] count,
    output logic       full
);

    lsu_req_t slot0, slot1;
    logic     push_ok, pop_ok;

    assign full    = (count == 2'd2);
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != 2'd0);
    assign head    = slot0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_data;
                    else               slot1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lsu_cdb_unit.sv
// Load/store unit: queued memory ops, private word memory, CDB slot 1 broadcast.
// Optional build macro LSU_BOUNDS_CHECK_EN: out-of-range addresses read 16'hDEAD and block stores.
module lsu_cdb_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [ROB_IDX_W-1:0] issue_rob_idx,
    input  logic [OPC_W-1:0]     issue_opcode,
    input  logic [DATA_W-1:0]    issue_a_value,
    input  logic [DATA_W-1:0]    issue_b_value,
    output logic                 lsu_full,
    output logic                 cdb_valid,
    output logic [ROB_IDX_W-1:0] cdb_rob_index,
    output logic [DATA_W-1:0]    cdb_result
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    lsu_state_t        state;
    logic [CNT_W-1:0]  cnt;
    lsu_req_t          cur;
    lsu_req_t          head;
    lsu_req_t          issue_req;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [ADDR_W-1:0] mem_addr;
    logic              addr_oob;
    logic              access_done;
    logic              mem_we;
    logic [DATA_W-1:0] op_result;
    logic [DATA_W-1:0] mem [DEPTH];

    assign issue_req = '{rob_idx: issue_rob_idx, opcode: issue_opcode,
                         a_value: issue_a_value, b_value: issue_b_value};

    assign fifo_empty = (fifo_count == 2'd0);
    assign fifo_push  = issue_valid && !lsu_full && !flush;
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty && !flush;

    lsu_req_fifo u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (issue_req),
        .pop       (fifo_pop),
        .head      (head),
        .count     (fifo_count),
        .full      (lsu_full)
    );

    assign mem_addr = ADDR_W'(cur.a_value % DEPTH);

`ifdef LSU_BOUNDS_CHECK_EN
    assign addr_oob = (32'(cur.a_value) >= DEPTH);
`else
    assign addr_oob = 1'b0;
`endif

    assign access_done = (state == ST_ACCESS) && (cnt == '0);
    // A store caught by flush or reset on its final ACCESS cycle never lands.
    assign mem_we = access_done && (cur.opcode == OP_ST) && !addr_oob && !flush && !rst;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        op_result = '0;
        if (cur.opcode == OP_LD) begin
            op_result = addr_oob ? BAD_ADDR_DATA : mem[mem_addr];
        end
    end

    // NOTE: the data memory has no reset; rst only clears control state, so
    // committed stores survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= cur.b_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            cdb_valid     <= 1'b0;
            cdb_rob_index <= '0;
            cdb_result    <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cdb_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur   <= head;
                        cnt   <= CNT_INIT;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cdb_rob_index <= cur.rob_idx;
                        cdb_result    <= op_result;
                        cdb_valid     <= 1'b1;
                        state         <= ST_BCAST;
                    end
                end
                ST_BCAST: begin
                    cdb_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    cdb_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_cdb_unit.sv
// Self-checking bench for lsu_cdb_unit: directed scenarios plus randomized traffic vs a scheduling model.
module tb_lsu_cdb_unit;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_rob_idx = '0;
    logic [3:0]  issue_opcode = '0;
    logic [15:0] issue_a_value = '0;
    logic [15:0] issue_b_value = '0;
    logic        lsu_full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_index;
    logic [15:0] cdb_result;

    always #5 clk = ~clk;

    lsu_cdb_unit #(.DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_rob_idx (issue_rob_idx),
        .issue_opcode  (issue_opcode),
        .issue_a_value (issue_a_value),
        .issue_b_value (issue_b_value),
        .lsu_full      (lsu_full),
        .cdb_valid     (cdb_valid),
        .cdb_rob_index (cdb_rob_index),
        .cdb_result    (cdb_result)
    );

    // Model: each accepted op is scheduled by edge number; the unit serves one
    // op at a time, starting no earlier than the edge after acceptance and
    // spaced LAT+2 edges apart; it broadcasts LAT edges after it starts.
    typedef struct {
        logic [3:0]  rob;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          acc;
        int          start;
        int          bcast;
    } mop_t;

    typedef struct {
        int          edge_no;
        logic [3:0]  rob;
        logic [15:0] res;
    } bc_t;

    mop_t        pend[$];
    bc_t         log_q[$];
    logic [15:0] mmem [DEPTH];
    int          total = 0;
    int          bad = 0;
    int          ecnt = 0;
    int          last_start = -100;
    logic [3:0]  last_rob = '0;
    logic [15:0] last_res = '0;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic bit model_full(input int e);
        int n = 0;
        foreach (pend[i]) if (pend[i].acc <= e && pend[i].start > e) n++;
        return n == 2;
    endfunction

    function automatic logic [15:0] model_exec(input mop_t m);
        int addr;
        bit oob;
        addr = int'(m.a) % DEPTH;
        oob  = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
        oob = (int'(m.a) >= DEPTH);
`endif
        if (m.op == 4'hA) return oob ? 16'hDEAD : mmem[addr];
        if (m.op == 4'hB && !oob) mmem[addr] = m.b;
        return 16'h0000;
    endfunction

    // One clock: drive inputs, advance the model, then check outputs on the falling edge.
    task automatic tick(input bit iv, input logic [3:0] rob, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input bit fl, input bit rs);
        int   k;
        bit   mfull;
        bit   exp_valid;
        mop_t m;
        k     = ecnt + 1;
        mfull = model_full(ecnt);
        issue_valid = iv; issue_rob_idx = rob; issue_opcode = op;
        issue_a_value = a; issue_b_value = b; flush = fl; rst = rs;
        if (rs || fl) begin
            pend.delete();
            last_start = -100;
            if (rs) begin
                last_rob = '0;
                last_res = '0;
            end
        end else if (iv && !mfull) begin
            m.rob = rob; m.op = op; m.a = a; m.b = b; m.acc = k;
            m.start = (k + 1 > last_start + LAT + 2) ? k + 1 : last_start + LAT + 2;
            m.bcast = m.start + LAT;
            last_start = m.start;
            pend.push_back(m);
        end
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0; flush = 1'b0; rst = 1'b0;
        exp_valid = (pend.size() > 0) && (pend[0].bcast == k);
        total++;
        if (lsu_full !== model_full(k)) begin
            bad++;
            $display("FAIL lsu_full edge=%0d got=%b exp=%b", k, lsu_full, model_full(k));
        end
        total++;
        if (cdb_valid !== exp_valid) begin
            bad++;
            $display("FAIL cdb_valid edge=%0d got=%b exp=%b", k, cdb_valid, exp_valid);
        end
        if (exp_valid) begin
            m = pend.pop_front();
            last_rob = m.rob;
            last_res = model_exec(m);
        end
        total++;
        if (cdb_rob_index !== last_rob) begin
            bad++;
            $display("FAIL cdb_rob_index edge=%0d got=%h exp=%h", k, cdb_rob_index, last_rob);
        end
        total++;
        if (cdb_result !== last_res) begin
            bad++;
            $display("FAIL cdb_result edge=%0d got=%h exp=%h", k, cdb_result, last_res);
        end
        if (cdb_valid === 1'b1) log_q.push_back('{k, cdb_rob_index, cdb_result});
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        tick(1'b1, 4'h2, 4'hA, 16'h0, 16'h0, 1'b1, 1'b1);
        total++;
        if (lsu_full !== 1'b0 || cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got full=%b valid=%b exp full=0 valid=0", lsu_full, cdb_valid);
        end
        total++;
        if (cdb_rob_index !== 4'h0 || cdb_result !== 16'h0) begin
            bad++;
            $display("FAIL reset_data got rob=%h res=%h exp rob=0 res=0", cdb_rob_index, cdb_result);
        end
    endtask

    task automatic test_st_ld();
        int k0;
        log_q.delete();
        k0 = ecnt + 1;
        tick(1'b1, 4'h3, 4'hB, 16'h0010, 16'h1234, 1'b0, 1'b0);
        tick(1'b1, 4'h4, 4'hA, 16'h0010, 16'h0000, 1'b0, 1'b0);
        idle(12);
        total++;
        if (log_q.size() != 2) begin
            bad++;
            $display("FAIL st_ld_count got=%0d exp=2", log_q.size());
        end else begin
            total++;
            if (log_q[0].rob !== 4'h3 || log_q[0].res !== 16'h0000) begin
                bad++;
                $display("FAIL st_bcast got=(%h,%h) exp=(3,0000)", log_q[0].rob, log_q[0].res);
            end
            total++;
            if (log_q[1].rob !== 4'h4 || log_q[1].res !== 16'h1234) begin
                bad++;
                $display("FAIL ld_bcast got=(%h,%h) exp=(4,1234)", log_q[1].rob, log_q[1].res);
            end
            total++;
            if (log_q[0].edge_no != k0 + 1 + LAT) begin
                bad++;
                $display("FAIL first_latency got=%0d exp=%0d", log_q[0].edge_no - k0, 1 + LAT);
            end
            total++;
            if (log_q[1].edge_no - log_q[0].edge_no != LAT + 2) begin
                bad++;
                $display("FAIL throughput got=%0d exp=%0d", log_q[1].edge_no - log_q[0].edge_no, LAT + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        log_q.delete();
        tick(1'b1, 4'h1, 4'hA, 16'h0001, 16'h0, 1'b0, 1'b0);
        tick(1'b1, 4'h2, 4'hA, 16'h0002, 16'h0, 1'b0, 1'b0);
        tick(1'b1, 4'h9, 4'h3, 16'h0003, 16'h0, 1'b0, 1'b0);
        total++;
        if (lsu_full !== 1'b1) begin
            bad++;
            $display("FAIL full_after_third got=%b exp=1", lsu_full);
        end
        tick(1'b1, 4'hA, 4'hA, 16'h0010, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && lsu_full !== 1'b0; i++) idle(1);
        total++;
        if (lsu_full !== 1'b0) begin
            bad++;
            $display("FAIL full_release got=%b exp=0", lsu_full);
        end
        tick(1'b1, 4'hA, 4'hA, 16'h0010, 16'h0, 1'b0, 1'b0);
        idle(20);
        total++;
        if (log_q.size() != 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=4", log_q.size());
        end else begin
            total++;
            if (log_q[0].rob !== 4'h1 || log_q[1].rob !== 4'h2 ||
                log_q[2].rob !== 4'h9 || log_q[3].rob !== 4'hA) begin
                bad++;
                $display("FAIL b2b_order got=%h,%h,%h,%h exp=1,2,9,a",
                         log_q[0].rob, log_q[1].rob, log_q[2].rob, log_q[3].rob);
            end
            total++;
            if (log_q[3].res !== 16'h1234) begin
                bad++;
                $display("FAIL b2b_reissue_data got=%h exp=1234", log_q[3].res);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_wrap, exp_alias;
`ifdef LSU_BOUNDS_CHECK_EN
        exp_wrap  = 16'hDEAD;
        exp_alias = 16'h0000;
`else
        exp_wrap  = 16'h1234;
        exp_alias = 16'h5555;
`endif
        log_q.delete();
        tick(1'b1, 4'h1, 4'hB, 16'h0130, 16'h5555, 1'b0, 1'b0);
        tick(1'b1, 4'h2, 4'hA, 16'h0110, 16'h0000, 1'b0, 1'b0);
        tick(1'b1, 4'h3, 4'hA, 16'h0030, 16'h0000, 1'b0, 1'b0);
        idle(16);
        total++;
        if (log_q.size() != 3) begin
            bad++;
            $display("FAIL wrap_count got=%0d exp=3", log_q.size());
        end else begin
            total++;
            if (log_q[1].res !== exp_wrap) begin
                bad++;
                $display("FAIL wrap_load got=%h exp=%h", log_q[1].res, exp_wrap);
            end
            total++;
            if (log_q[2].res !== exp_alias) begin
                bad++;
                $display("FAIL wrap_store got=%h exp=%h", log_q[2].res, exp_alias);
            end
        end
    endtask

    task automatic test_flush_access();
        log_q.delete();
        tick(1'b1, 4'h5, 4'hB, 16'h0020, 16'hBEEF, 1'b0, 1'b0);
        idle(2);
        tick(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_valid got=%b exp=0", cdb_valid);
        end
        idle(6);
        total++;
        if (log_q.size() != 0) begin
            bad++;
            $display("FAIL flush_dropped got=%0d exp=0", log_q.size());
        end
        tick(1'b1, 4'h6, 4'hA, 16'h0020, 16'h0000, 1'b0, 1'b0);
        idle(6);
        total++;
        if (log_q.size() != 1 || log_q[0].res !== 16'h0000) begin
            bad++;
            $display("FAIL flush_store_lost got=%0d entries exp=1 with result 0000", log_q.size());
        end
    endtask

    task automatic test_flush_issue();
        log_q.delete();
        tick(1'b1, 4'hC, 4'hA, 16'h0000, 16'h0000, 1'b1, 1'b0);
        total++;
        if (lsu_full !== 1'b0) begin
            bad++;
            $display("FAIL flush_issue_full got=%b exp=0", lsu_full);
        end
        idle(8);
        total++;
        if (log_q.size() != 0) begin
            bad++;
            $display("FAIL flush_issue_bcast got=%0d exp=0", log_q.size());
        end
    endtask

    task automatic test_rst_access();
        log_q.delete();
        tick(1'b1, 4'h7, 4'hB, 16'h0040, 16'h7777, 1'b0, 1'b0);
        idle(6);
        tick(1'b1, 4'h8, 4'hB, 16'h0050, 16'h8888, 1'b0, 1'b0);
        idle(2);
        tick(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        total++;
        if (cdb_valid !== 1'b0 || lsu_full !== 1'b0 || cdb_rob_index !== 4'h0) begin
            bad++;
            $display("FAIL rst_mid got valid=%b full=%b rob=%h exp 0,0,0", cdb_valid, lsu_full, cdb_rob_index);
        end
        tick(1'b1, 4'h9, 4'hA, 16'h0040, 16'h0000, 1'b0, 1'b0);
        tick(1'b1, 4'hA, 4'hA, 16'h0050, 16'h0000, 1'b0, 1'b0);
        idle(12);
        total++;
        if (log_q.size() != 3) begin
            bad++;
            $display("FAIL rst_count got=%0d exp=3", log_q.size());
        end else begin
            total++;
            if (log_q[1].res !== 16'h7777 || log_q[2].res !== 16'h0000) begin
                bad++;
                $display("FAIL rst_mem got=%h,%h exp=7777,0000", log_q[1].res, log_q[2].res);
            end
        end
    endtask

    task automatic test_random();
        bit          iv, fl;
        logic [3:0]  rob, op;
        logic [15:0] a, b;
        int          r;
        for (int i = 0; i < 600; i++) begin
            iv  = ($urandom_range(0, 99) < 60);
            fl  = ($urandom_range(0, 99) < 2);
            rob = 4'($urandom);
            r   = $urandom_range(0, 9);
            op  = (r < 4) ? 4'hA : (r < 8) ? 4'hB : 4'($urandom);
            a   = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            b   = 16'($urandom);
            tick(iv, rob, op, a, b, fl, 1'b0);
        end
        idle(10);
    endtask

    initial begin
        foreach (mmem[i]) mmem[i] = 16'h0000;
        @(negedge clk);
        test_reset();
        test_st_ld();
        test_back_to_back();
        test_wrap();
        test_flush_access();
        test_flush_issue();
        test_rst_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
